// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator answering a host start pulse with ACK and a 40-bit frame
module dht11_responder #(
    parameter int CLKS_PER_US   = 50,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int ACK_LOW_US    = 80,
    parameter int ACK_HIGH_US   = 80,
    parameter int BIT_LOW_US    = 50,
    parameter int BIT0_HIGH_US  = 26,
    parameter int BIT1_HIGH_US  = 70,
    parameter int GUARD_CLKS    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] hum1_i,
    input  logic [7:0] hum2_i,
    input  logic [7:0] temp1_i,
    input  logic [7:0] temp2_i,
    input  logic       load_i,
    input  logic       corrupt_i,
    input  logic       dht_i,
    output logic       dht_oe_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       abort_o
);
    localparam int PW = $clog2(CLKS_PER_US + 1);
    localparam int GW = $clog2(GUARD_CLKS + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START_LO, S_START_OK, S_RESP_DELAY, S_ACK_LO,
        S_ACK_HI, S_BIT_LO, S_BIT_HI, S_END_LO
    } state_t;

    state_t      r_state;
    logic [1:0]  r_sync;
    logic [PW-1:0] r_pre;
    logic [15:0] r_us;
    logic [GW-1:0] r_guard;
    logic [39:0] r_shift;
    logic [5:0]  r_idx;
    logic [7:0]  r_h1, r_h2, r_t1, r_t2;
    logic        r_oe, r_busy, r_done, r_abort;

    logic        w_ls;
    logic        w_tick;
    logic [15:0] w_lim;
    logic        w_end;
    logic        w_guard_ok;
    logic        w_contend;
    logic [7:0]  w_sum;

    assign w_ls       = r_sync[1];
    assign w_tick     = (r_pre == PW'(CLKS_PER_US - 1));
    assign w_end      = w_tick && (r_us == w_lim - 16'd1);
    assign w_guard_ok = (r_guard == GW'(GUARD_CLKS));
    assign w_sum      = r_h1 + r_h2 + r_t1 + r_t2;
    assign w_contend  = (r_state == S_RESP_DELAY || r_state == S_ACK_HI || r_state == S_BIT_HI)
                        && w_guard_ok && !w_ls;

    assign dht_oe_o = r_oe;
    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign abort_o  = r_abort;

    // Length in microseconds of the phase the FSM is currently timing
    always_comb begin
        w_lim = (r_state == S_START_LO)   ? 16'(START_MIN_US)  :
                (r_state == S_RESP_DELAY) ? 16'(RESP_DELAY_US) :
                (r_state == S_ACK_LO)     ? 16'(ACK_LOW_US)    :
                (r_state == S_ACK_HI)     ? 16'(ACK_HIGH_US)   :
                (r_state == S_BIT_HI)     ? (r_shift[39] ? 16'(BIT1_HIGH_US) : 16'(BIT0_HIGH_US)) :
                (r_state == S_BIT_LO || r_state == S_END_LO) ? 16'(BIT_LOW_US) : 16'd1;
    end

    // Two-flop synchronizer for the asynchronous line; idles high like the pulled-up wire
    always_ff @(posedge clk) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], dht_i};
    end

    // Free-running microsecond prescaler
    always_ff @(posedge clk) begin
        if (!rst_n) r_pre <= '0;
        else        r_pre <= w_tick ? '0 : r_pre + PW'(1);
    end

    // Staging registers, overwritten on every load strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h1 <= '0;
            r_h2 <= '0;
            r_t1 <= '0;
            r_t2 <= '0;
        end else if (load_i) begin
            r_h1 <= hum1_i;
            r_h2 <= hum2_i;
            r_t1 <= temp1_i;
            r_t2 <= temp2_i;
        end
    end

    // Protocol FSM with registered line drive and status; every transition clears the us and guard counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_us    <= '0;
            r_guard <= '0;
            r_shift <= '0;
            r_idx   <= '0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            r_us    <= r_us + {15'd0, w_tick};
            if (!w_guard_ok) r_guard <= r_guard + GW'(1);
            if (w_contend) begin
                r_state <= S_IDLE;
                r_us    <= '0;
                r_guard <= '0;
                r_oe    <= 1'b0;
                r_busy  <= 1'b0;
                r_abort <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_ls) begin
                            r_state <= S_START_LO;
                            r_us    <= '0;
                            r_guard <= '0;
                        end
                    end
                    S_START_LO: begin
                        if (w_ls) begin
                            r_state <= S_IDLE;
                            r_us    <= '0;
                            r_guard <= '0;
                        end else if (w_end) begin
                            r_state <= S_START_OK;
                            r_us    <= '0;
                            r_guard <= '0;
                        end
                    end
                    S_START_OK: begin
                        if (w_ls) begin
                            r_state <= S_RESP_DELAY;
                            r_us    <= '0;
                            r_guard <= '0;
                            r_busy  <= 1'b1;
                            r_shift <= {r_h1, r_h2, r_t1, r_t2, w_sum ^ {7'd0, corrupt_i}};
                        end
                    end
                    S_RESP_DELAY: begin
                        if (w_end) begin
                            r_state <= S_ACK_LO;
                            r_us    <= '0;
                            r_guard <= '0;
                            r_oe    <= 1'b1;
                        end
                    end
                    S_ACK_LO: begin
                        if (w_end) begin
                            r_state <= S_ACK_HI;
                            r_us    <= '0;
                            r_guard <= '0;
                            r_oe    <= 1'b0;
                        end
                    end
                    S_ACK_HI: begin
                        if (w_end) begin
                            r_state <= S_BIT_LO;
                            r_us    <= '0;
                            r_guard <= '0;
                            r_idx   <= '0;
                            r_oe    <= 1'b1;
                        end
                    end
                    S_BIT_LO: begin
                        if (w_end) begin
                            r_state <= S_BIT_HI;
                            r_us    <= '0;
                            r_guard <= '0;
                            r_oe    <= 1'b0;
                        end
                    end
                    S_BIT_HI: begin
                        if (w_end) begin
                            r_state <= (r_idx == 6'd39) ? S_END_LO : S_BIT_LO;
                            r_us    <= '0;
                            r_guard <= '0;
                            r_shift <= {r_shift[38:0], 1'b0};
                            r_idx   <= r_idx + 6'd1;
                            r_oe    <= 1'b1;
                        end
                    end
                    S_END_LO: begin
                        if (w_end) begin
                            r_state <= S_IDLE;
                            r_us    <= '0;
                            r_guard <= '0;
                            r_oe    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
